// File: rtl/acc_tok_pkg.sv
// Shared types and constants for the accumulator token sender.
package acc_tok_pkg;

  localparam int unsigned Q47_WIDTH = 8;
  localparam logic [1:0]  CLR_CODE  = 2'd1;

  typedef enum logic [2:0] {
    IDLE,
    D_SETUP,
    D_REQ,
    D_RTZ,
    C_SETUP,
    C_REQ,
    C_RTZ
  } state_t;

endpackage

// File: rtl/ack_sync.sv
// Two-flop synchroniser for an asynchronous acknowledge, cleared by synchronous reset.
module ack_sync (
  input  logic clk,
  input  logic rst,
  input  logic ack,
  output logic ack_s
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= 1'b0;
      ack_s <= 1'b0;
    end else begin
      meta  <= ack;
      ack_s <= meta;
    end
  end

endmodule

// File: rtl/acc_token_sender.sv
// Sends PE partial sums to the membrane accumulator as four-phase bundled-data
// tokens, followed by a clear token per group, last beat or flush.
module acc_token_sender
  import acc_tok_pkg::*;
#(
  parameter int unsigned WIDTH          = Q47_WIDTH,
  parameter int unsigned SUMS_PER_CLEAR = 4,
  parameter int unsigned SETUP_CYC      = 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        in_data,
  input  logic                                    in_last,
  input  logic                                    flush,
  output logic                                    data_req,
  output logic [WIDTH-1:0]                        data_bus,
  input  logic                                    data_ack,
  output logic                                    clr_req,
  output logic [1:0]                              clr_bus,
  input  logic                                    clr_ack,
  output logic [$clog2(SUMS_PER_CLEAR+1)-1:0]     tok_cnt,
  output logic                                    proto_err
);

  localparam int unsigned CNT_W = $clog2(SUMS_PER_CLEAR + 1);
  localparam int unsigned SET_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  state_t     state;
  logic [SET_W-1:0] setup_cnt;
  logic       last_q;
  logic       data_ack_s;
  logic       clr_ack_s;
  logic       data_ack_q;
  logic       clr_ack_q;

  ack_sync u_data_sync (.clk(clk), .rst(rst), .ack(data_ack), .ack_s(data_ack_s));
  ack_sync u_clr_sync  (.clk(clk), .rst(rst), .ack(clr_ack),  .ack_s(clr_ack_s));

  // Handshake FSM; a flush in IDLE pre-empts a simultaneous in_valid, which stays pending upstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      data_req   <= 1'b0;
      data_bus   <= '0;
      clr_req    <= 1'b0;
      clr_bus    <= '0;
      tok_cnt    <= '0;
      proto_err  <= 1'b0;
      setup_cnt  <= '0;
      last_q     <= 1'b0;
      data_ack_q <= 1'b0;
      clr_ack_q  <= 1'b0;
    end else begin
      data_ack_q <= data_ack_s;
      clr_ack_q  <= clr_ack_s;
      // An ack rising with its req low is a downstream protocol violation.
      if ((data_ack_s && !data_ack_q && !data_req) ||
          (clr_ack_s && !clr_ack_q && !clr_req)) begin
        proto_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (flush) begin
            in_ready  <= 1'b0;
            clr_bus   <= CLR_CODE;
            setup_cnt <= '0;
            state     <= C_SETUP;
          end else if (in_valid && in_ready) begin
            in_ready  <= 1'b0;
            data_bus  <= in_data;
            last_q    <= in_last;
            setup_cnt <= '0;
            state     <= D_SETUP;
          end else begin
            in_ready  <= 1'b1;
          end
        end
        D_SETUP: begin
          if (setup_cnt == SET_W'(SETUP_CYC - 1)) begin
            data_req <= 1'b1;
            state    <= D_REQ;
          end else begin
            setup_cnt <= setup_cnt + SET_W'(1);
          end
        end
        D_REQ: begin
          if (data_ack_s) begin
            data_req <= 1'b0;
            tok_cnt  <= tok_cnt + CNT_W'(1);
            state    <= D_RTZ;
          end
        end
        D_RTZ: begin
          if (!data_ack_s) begin
            if (tok_cnt == CNT_W'(SUMS_PER_CLEAR) || last_q) begin
              clr_bus   <= CLR_CODE;
              setup_cnt <= '0;
              state     <= C_SETUP;
            end else begin
              in_ready <= 1'b1;
              state    <= IDLE;
            end
          end
        end
        C_SETUP: begin
          if (setup_cnt == SET_W'(SETUP_CYC - 1)) begin
            clr_req <= 1'b1;
            state   <= C_REQ;
          end else begin
            setup_cnt <= setup_cnt + SET_W'(1);
          end
        end
        C_REQ: begin
          if (clr_ack_s) begin
            clr_req <= 1'b0;
            state   <= C_RTZ;
          end
        end
        C_RTZ: begin
          if (!clr_ack_s) begin
            tok_cnt  <= '0;
            clr_bus  <= '0;
            in_ready <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acc_token_sender.sv
// Directed bench for acc_token_sender with a four-phase ack responder and a handshake monitor.
module tb_acc_token_sender;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned SPC   = 4;
  localparam int unsigned SETUP = 1;
  localparam int unsigned CNT_W = $clog2(SPC + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             flush;
  logic             data_req;
  logic [WIDTH-1:0] data_bus;
  logic             data_ack;
  logic             clr_req;
  logic [1:0]       clr_bus;
  logic             clr_ack;
  logic [CNT_W-1:0] tok_cnt;
  logic             proto_err;

  logic resp_d_ack = 1'b0;
  logic resp_c_ack = 1'b0;
  logic pulse_ack  = 1'b0;
  int   dly        = 1;

  assign data_ack = resp_d_ack | pulse_ack;
  assign clr_ack  = resp_c_ack;

  always #5 clk = ~clk;

  acc_token_sender #(.WIDTH(WIDTH), .SUMS_PER_CLEAR(SPC), .SETUP_CYC(SETUP)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .flush(flush),
    .data_req(data_req), .data_bus(data_bus), .data_ack(data_ack),
    .clr_req(clr_req), .clr_bus(clr_bus), .clr_ack(clr_ack),
    .tok_cnt(tok_cnt), .proto_err(proto_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Downstream accumulator model: each ack follows its req after dly cycles.
  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      if (data_req != resp_d_ack) begin
        n++;
        if (n >= dly) begin resp_d_ack = data_req; n = 0; end
      end else n = 0;
    end
  end

  initial begin
    int n = 0;
    forever begin
      @(negedge clk);
      if (clr_req != resp_c_ack) begin
        n++;
        if (n >= dly) begin resp_c_ack = clr_req; n = 0; end
      end else n = 0;
    end
  end

  // Handshake monitor: token log (0x100 marks a clear), bus stability, exclusivity.
  logic [8:0]       log_q[$];
  logic [8:0]       exp_q[$];
  logic [WIDTH-1:0] held_bus = '0;
  logic             prev_dreq = 1'b0;
  logic             prev_creq = 1'b0;
  int               dlen = 0;
  int               last_dlen = 0;
  logic [CNT_W-1:0] tok_at_clr = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (data_req && !prev_dreq) begin
        held_bus = data_bus;
        log_q.push_back({1'b0, data_bus});
        dlen = 0;
      end
      if (data_req) begin
        dlen++;
        check_eq("dbus_stable", 32'(data_bus), 32'(held_bus));
        check_eq("rdy_busy_d", 32'(in_ready), 32'd0);
      end
      if (!data_req && prev_dreq) last_dlen = dlen;
      if (clr_req && !prev_creq) begin
        log_q.push_back(9'h100);
        tok_at_clr = tok_cnt;
      end
      if (clr_req) begin
        check_eq("clr_code", 32'(clr_bus), 32'd1);
        check_eq("rdy_busy_c", 32'(in_ready), 32'd0);
      end
      check_eq("req_excl", 32'(data_req & clr_req), 32'd0);
      prev_dreq = data_req;
      prev_creq = clr_req;
    end
  end

  task automatic compare_log(input string tag);
    check_eq({tag, "_len"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
      check_eq(tag, 32'(log_q[i]), 32'(exp_q[i]));
    log_q.delete();
    exp_q.delete();
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input logic [WIDTH-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    check_eq("send_accept", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(in_ready && !data_req && !clr_req) && n < 400) begin @(negedge clk); n++; end
    check_eq({tag, "_idle"}, 32'(in_ready & ~data_req & ~clr_req), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_data_req", 32'(data_req), 32'd0);
    check_eq("rst_clr_req", 32'(clr_req), 32'd0);
    check_eq("rst_data_bus", 32'(data_bus), 32'd0);
    check_eq("rst_clr_bus", 32'(clr_bus), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd0);
    check_eq("rst_tok_cnt", 32'(tok_cnt), 32'd0);
    check_eq("rst_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rdy_after_rst", 32'(in_ready), 32'd1);

    // Full group of four tokens then automatic clear.
    for (int i = 0; i < 4; i++) begin
      send(8'(8'h10 * (i + 1)), 1'b0);
      wait_idle("t1");
      check_eq("t1_tok_cnt", 32'(tok_cnt), (i < 3) ? 32'(i + 1) : 32'd0);
    end
    check_eq("t1_dreq_len", 32'(last_dlen), 32'd3);
    check_eq("t1_tok_at_clr", 32'(tok_at_clr), 32'd4);
    exp_q = '{9'h010, 9'h020, 9'h030, 9'h040, 9'h100};
    compare_log("t1_log");

    // in_last forces an early clear.
    send(8'h7F, 1'b1);
    wait_idle("t2");
    check_eq("t2_tok_at_clr", 32'(tok_at_clr), 32'd1);
    check_eq("t2_tok_cnt", 32'(tok_cnt), 32'd0);
    exp_q = '{9'h07F, 9'h100};
    compare_log("t2_log");

    // flush beats a simultaneous in_valid; data goes afterwards.
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    @(negedge clk);
    flush = 1'b0;
    check_eq("t3_rdy_low", 32'(in_ready), 32'd0);
    send(8'h55, 1'b0);
    wait_idle("t3");
    check_eq("t3_tok_at_clr", 32'(tok_at_clr), 32'd0);
    check_eq("t3_tok_cnt", 32'(tok_cnt), 32'd1);
    exp_q = '{9'h100, 9'h055};
    compare_log("t3_log");

    // Slow acknowledge: req held 20 + 2 cycles.
    dly = 20;
    send(8'hA5, 1'b0);
    wait_idle("t4");
    check_eq("t4_dreq_len", 32'(last_dlen), 32'd22);
    check_eq("t4_tok_cnt", 32'(tok_cnt), 32'd2);
    exp_q = '{9'h0A5};
    compare_log("t4_log");
    dly = 1;

    // Spurious ack while idle sets sticky proto_err only.
    pulse_ack = 1'b1;
    repeat (2) @(negedge clk);
    pulse_ack = 1'b0;
    repeat (4) @(negedge clk);
    check_eq("t5_proto_err", 32'(proto_err), 32'd1);
    check_eq("t5_in_ready", 32'(in_ready), 32'd1);
    check_eq("t5_data_req", 32'(data_req), 32'd0);
    check_eq("t5_tok_cnt", 32'(tok_cnt), 32'd2);
    repeat (5) @(negedge clk);
    check_eq("t5_sticky", 32'(proto_err), 32'd1);

    // Reset while data_req is high.
    in_valid = 1'b1; in_data = 8'h3C;
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int n = 0;
      while (!data_req && n < 50) begin @(negedge clk); n++; end
    end
    check_eq("t6_in_dreq", 32'(data_req), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_dreq", 32'(data_req), 32'd0);
    check_eq("t6_rst_rdy", 32'(in_ready), 32'd0);
    check_eq("t6_rst_perr", 32'(proto_err), 32'd0);
    check_eq("t6_rst_tok", 32'(tok_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_rdy_after", 32'(in_ready), 32'd1);
    send(8'h66, 1'b0);
    wait_idle("t6");
    check_eq("t6_tok_cnt", 32'(tok_cnt), 32'd1);
    check_eq("t6_perr", 32'(proto_err), 32'd0);
    check_eq("t6_dreq_len", 32'(last_dlen), 32'd3);
    exp_q = '{9'h03C, 9'h066};
    compare_log("t6_log");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
